// File: rtl/system_led_gpio_if.sv
// Peripheral bus bundle shared by the SoC GPIO blocks: strobes, address,
// write payload and combinational read data.
interface system_led_gpio_if;
  logic [2:0] addr;
  logic       write;
  logic [7:0] writeData;
  logic       read;
  logic [7:0] readData;

  modport master (output addr, write, writeData, read, input readData);
  modport slave  (input addr, write, writeData, read, output readData);
endinterface

// File: rtl/system_led_gpio.sv
// Output GPIO for eight board LEDs: direct/set/clear/toggle writes plus a
// per-LED hardware blink engine driven by a prescaler and a period counter.
module system_led_gpio #(
  parameter int PRESCALE = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  system_led_gpio_if.slave         bus,
  output logic [7:0]               leds
);

  localparam logic [2:0] ADDR_VALUE  = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_MASK   = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_PINS   = 3'd6;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [7:0]    value_q;
  logic [7:0]    mask_q;
  logic [7:0]    period_q;
  logic [7:0]    per_cnt;
  logic [PW-1:0] pre_cnt;
  logic          phase;
  logic          tick;
  logic          period_wr;

  assign tick      = (pre_cnt == PW'(PRESCALE - 1));
  assign period_wr = bus.write && (bus.addr == ADDR_PERIOD);

  // NOTE: every flop below is updated with <= so all registers sample the
  // same pre-edge state; blocking = here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q  <= '0;
      mask_q   <= '0;
      period_q <= '0;
    end else if (bus.write) begin
      case (bus.addr)
        ADDR_VALUE:  value_q  <= bus.writeData;
        ADDR_SET:    value_q  <= value_q | bus.writeData;
        ADDR_CLEAR:  value_q  <= value_q & ~bus.writeData;
        ADDR_TOGGLE: value_q  <= value_q ^ bus.writeData;
        ADDR_MASK:   mask_q   <= bus.writeData;
        ADDR_PERIOD: period_q <= bus.writeData;
        default:     ;
      endcase
    end
  end

  // A PERIOD write restarts blinking from a known phase and wins over a
  // coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      per_cnt <= '0;
      phase   <= 1'b0;
    end else if (period_wr) begin
      pre_cnt <= '0;
      per_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) begin
        if (per_cnt == period_q) begin
          per_cnt <= '0;
          phase   <= ~phase;
        end else begin
          per_cnt <= per_cnt + 8'd1;
        end
      end
    end
  end

  // Driven purely from flops so the pins never glitch with bus activity.
  assign leds = value_q ^ (mask_q & {8{phase}});

  // NOTE: readData gets a default before the case so no latch is inferred
  // for unlisted addresses or when read is low.
  always_comb begin
    bus.readData = '0;
    if (bus.read) begin
      case (bus.addr)
        ADDR_VALUE:  bus.readData = value_q;
        ADDR_MASK:   bus.readData = mask_q;
        ADDR_PERIOD: bus.readData = period_q;
        ADDR_PINS:   bus.readData = leds;
        default:     bus.readData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_system_led_gpio.sv
// Directed bench for system_led_gpio with PRESCALE=4; inputs change on the
// falling edge and outputs are sampled there, away from the rising edge.
module tb_system_led_gpio;

  logic       clk;
  logic       reset;
  logic [7:0] leds;
  logic [7:0] rd;
  int         total;
  int         bad;

  system_led_gpio_if bus ();

  system_led_gpio #(.PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .leds  (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge, after the
  // rising edge that registered the write.
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    bus.addr      = a;
    bus.writeData = d;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    bus.addr = a;
    bus.read = 1'b1;
    #1;
    d = bus.readData;
    bus.read = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.addr = '0; bus.write = 1'b0; bus.writeData = '0; bus.read = 1'b0;
    reset = 1'b1;
    #12;
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-operation, observed without any clock edge.
    bus_write(3'd0, 8'h55);
    bus_write(3'd4, 8'hF0);
    bus_write(3'd5, 8'h03);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_leds", leds, 8'h00);
    bus_read(3'd0, rd); check("reset_value", rd, 8'h00);
    bus_read(3'd4, rd); check("reset_mask", rd, 8'h00);
    bus_read(3'd5, rd); check("reset_period", rd, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Direct and atomic writes.
    bus_write(3'd0, 8'hA5);
    check("value_leds", leds, 8'hA5);
    bus_read(3'd6, rd); check("pins_read", rd, 8'hA5);
    @(negedge clk);
    bus_write(3'd1, 8'h0A);
    bus_read(3'd0, rd); check("set", rd, 8'hAF);
    @(negedge clk);
    bus_write(3'd2, 8'h81);
    bus_read(3'd0, rd); check("clear", rd, 8'h2E);
    @(negedge clk);
    bus_write(3'd3, 8'hFF);
    bus_read(3'd0, rd); check("toggle", rd, 8'hD1);
    check("toggle_leds", leds, 8'hD1);
    bus_read(3'd2, rd); check("read_wo_reg", rd, 8'h00);
    @(negedge clk);

    // TOGGLE held two cycles returns VALUE to where it started.
    bus.addr = 3'd3; bus.writeData = 8'h3C; bus.write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.write = 1'b0;
    bus_read(3'd0, rd); check("toggle_twice", rd, 8'hD1);
    @(negedge clk);

    // Blink timing: each level lasts exactly 8 cycles after the PERIOD write.
    bus_write(3'd0, 8'h00);
    bus_write(3'd4, 8'h03);
    bus_write(3'd5, 8'h01);
    check("blink_start", leds, 8'h00);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("blink_lo_%0d", i), leds, 8'h00);
    end
    @(negedge clk);
    check("blink_rise", leds, 8'h03);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("blink_hi_%0d", i), leds, 8'h03);
    end
    @(negedge clk);
    check("blink_fall", leds, 8'h00);

    // PERIOD write lands on the edge where phase would rise.
    repeat (7) @(negedge clk);
    check("collide_pre", leds, 8'h00);
    bus_write(3'd5, 8'h01);
    check("collide_edge", leds, 8'h00);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("collide_lo_%0d", i), leds, 8'h00);
    end
    @(negedge clk);
    check("collide_rise", leds, 8'h03);

    // Mask removed while phase=1: LEDs fall back to VALUE at once.
    bus_write(3'd0, 8'h0F);
    bus_write(3'd4, 8'hFF);
    bus_write(3'd5, 8'h01);
    repeat (8) @(negedge clk);
    check("mask_phase1", leds, 8'hF0);
    bus_write(3'd4, 8'h00);
    check("mask_clear", leds, 8'h0F);

    // Reserved address write changes nothing.
    bus_write(3'd7, 8'hFF);
    bus_read(3'd0, rd); check("addr7_value", rd, 8'h0F);
    bus_read(3'd4, rd); check("addr7_mask", rd, 8'h00);
    bus_read(3'd5, rd); check("addr7_period", rd, 8'h01);
    bus_read(3'd7, rd); check("addr7_read", rd, 8'h00);

    // read low returns 0 regardless of address.
    bus.read = 1'b0;
    bus.addr = 3'd0;
    #1;
    check("read_low", bus.readData, 8'h00);
    @(negedge clk);

    // Same-cycle read and write of VALUE sees the old value first.
    bus.addr = 3'd0; bus.writeData = 8'h3C; bus.write = 1'b1; bus.read = 1'b1;
    #1;
    check("rw_old", bus.readData, 8'h0F);
    @(negedge clk);
    bus.write = 1'b0;
    #1;
    check("rw_new", bus.readData, 8'h3C);
    bus.read = 1'b0;
    check("rw_leds", leds, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
